// File: rtl/stall_fifo.sv
// First-word-fall-through FIFO that holds ID-stage bundles across load-use stalls.
// Circular buffer with occupancy count, watermark flags, redirect flush and sticky error flags.
module stall_fifo #(
  parameter int unsigned WIDTH    = 121,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned PW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (32'(count) >= AF_LEVEL);
  assign almost_empty = (32'(count) <= AE_LEVEL);
  assign pop_data     = empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & ~push_ok) overflow  <= 1'b1;
      if (pop & empty)     underflow <= 1'b1;
    end
  end

  // Storage is not reset; only the write side touches it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_stall_fifo.sv
// Bench for stall_fifo: DEPTH=4 and DEPTH=3 instances checked every cycle against
// a shift-array reference model, plus directed literal expectations.
module tb_stall_fifo;

  logic       clk = 1'b0;
  logic [1:0] rst = '0, flush = '0, push = '0, pop = '0;
  logic [7:0] din  [2];
  logic [7:0] dout [2];
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  logic [1:0] full, empty, af, ae, ov, un;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stall_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst[0]), .flush(flush[0]), .push(push[0]), .push_data(din[0]),
    .pop(pop[0]), .pop_data(dout[0]), .count(cnt0), .full(full[0]), .empty(empty[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]), .underflow(un[0])
  );

  stall_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst[1]), .flush(flush[1]), .push(push[1]), .push_data(din[1]),
    .pop(pop[1]), .pop_data(dout[1]), .count(cnt1), .full(full[1]), .empty(empty[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]), .underflow(un[1])
  );

  // Reference model: element 0 is the head; pops shift the array down.
  logic [7:0] mq [2][8];
  int         mc   [2] = '{0, 0};
  bit         mov  [2] = '{0, 0};
  bit         mun  [2] = '{0, 0};
  bit         mval [2] = '{0, 0};

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_step(input int k);
    bit pok, puok;
    if (rst[k]) begin
      mc[k] = 0; mov[k] = 0; mun[k] = 0; mval[k] = 1;
    end else if (flush[k]) begin
      mc[k] = 0;
    end else begin
      pok  = pop[k] && (mc[k] > 0);
      puok = push[k] && ((mc[k] < depth_of(k)) || pok);
      if (push[k] && !puok) mov[k] = 1;
      if (pop[k] && mc[k] == 0) mun[k] = 1;
      if (pok) begin
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mc[k]--;
      end
      if (puok) begin
        mq[k][mc[k]] = din[k];
        mc[k]++;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[d%0d]: got %0h expected %0h at %0t", nm, depth_of(k), act, exp, $time);
  endtask

  function automatic int act_cnt(input int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  // Every-cycle comparison against the model once an instance has been reset.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mval[k]) begin
        chk("m_count", k, act_cnt(k), mc[k]);
        chk("m_empty", k, 32'(empty[k]), 32'(mc[k] == 0));
        chk("m_full",  k, 32'(full[k]),  32'(mc[k] == depth_of(k)));
        chk("m_afull", k, 32'(af[k]),    32'(mc[k] >= depth_of(k) - 1));
        chk("m_aempty", k, 32'(ae[k]),   32'(mc[k] <= 1));
        chk("m_data",  k, 32'(dout[k]),  (mc[k] > 0) ? 32'(mq[k][0]) : 0);
        chk("m_ovf",   k, 32'(ov[k]),    32'(mov[k]));
        chk("m_unf",   k, 32'(un[k]),    32'(mun[k]));
      end
    end
  end

  task automatic step(input int k, input bit r, input bit f, input bit pu, input bit po,
                      input logic [7:0] d);
    rst = '0; flush = '0; push = '0; pop = '0;
    rst[k] = r; flush[k] = f; push[k] = pu; pop[k] = po; din[k] = d;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = '0; flush = '0; push = '0; pop = '0;
  endtask

  // Fill, overflow, replace-at-full and wrap, shared by both depths.
  task automatic fill_and_wrap(input int k);
    logic [7:0] d;
    int dep;
    dep = depth_of(k);
    step(k, 1, 0, 0, 0, 8'h00);
    step(k, 0, 0, 0, 0, 8'h00);
    chk("rst_count", k, act_cnt(k), 0);
    chk("rst_empty", k, 32'(empty[k]), 1);
    chk("rst_data",  k, 32'(dout[k]), 0);
    chk("rst_aempty", k, 32'(ae[k]), 1);
    chk("rst_flags", k, {29'd0, full[k], ov[k], un[k]}, 0);
    for (int i = 0; i < dep; i++) begin
      d = 8'h11 * 8'(i + 1);
      step(k, 0, 0, 1, 0, d);
      chk("fill_count", k, act_cnt(k), i + 1);
      chk("fill_head",  k, 32'(dout[k]), 32'h11);
      chk("fill_afull", k, 32'(af[k]), 32'(i + 1 >= dep - 1));
    end
    chk("fill_full", k, 32'(full[k]), 1);
    step(k, 0, 0, 1, 0, 8'h55);
    chk("drop_ovf",   k, 32'(ov[k]), 1);
    chk("drop_count", k, act_cnt(k), dep);
    step(k, 0, 0, 1, 1, 8'h66);
    chk("repl_head",  k, 32'(dout[k]), 32'h22);
    chk("repl_count", k, act_cnt(k), dep);
    for (int i = 2; i < dep; i++) begin
      step(k, 0, 0, 0, 1, 8'h00);
      chk("drain_head", k, 32'(dout[k]), 32'h11 * (i + 1));
    end
    step(k, 0, 0, 0, 1, 8'h00);
    chk("last_is_66", k, 32'(dout[k]), 32'h66);
    step(k, 0, 0, 0, 1, 8'h00);
    chk("drained", k, act_cnt(k), 0);
    step(k, 0, 0, 1, 0, 8'h80);
    step(k, 0, 0, 1, 0, 8'h81);
    for (int i = 0; i < 10; i++) begin
      d = 8'h82 + 8'(i);
      step(k, 0, 0, 1, 1, d);
      chk("wrap_head",  k, 32'(dout[k]), 32'h81 + i);
      chk("wrap_count", k, act_cnt(k), 2);
    end
    step(k, 0, 0, 0, 1, 8'h00);
    step(k, 0, 0, 0, 1, 8'h00);
    chk("wrap_empty", k, 32'(empty[k]), 1);
    chk("wrap_unf",   k, 32'(un[k]), 0);
  endtask

  initial begin
    din[0] = '0;
    din[1] = '0;
    @(negedge clk);
    #1;
    fill_and_wrap(0);
    // Push with pop on empty: pop rejected, push lands, underflow sets.
    step(0, 0, 0, 1, 1, 8'hA5);
    chk("pe_count", 0, act_cnt(0), 1);
    chk("pe_unf",   0, 32'(un[0]), 1);
    chk("pe_data",  0, 32'(dout[0]), 32'hA5);
    step(0, 0, 0, 1, 0, 8'hB6);
    step(0, 0, 0, 1, 0, 8'hC7);
    chk("pre_flush", 0, act_cnt(0), 3);
    step(0, 0, 1, 1, 0, 8'hD8);
    chk("fl_count", 0, act_cnt(0), 0);
    chk("fl_empty", 0, 32'(empty[0]), 1);
    chk("fl_data",  0, 32'(dout[0]), 0);
    chk("fl_sticky", 0, {30'd0, ov[0], un[0]}, 3);
    step(0, 0, 0, 1, 0, 8'h3C);
    chk("post_fl_data", 0, 32'(dout[0]), 32'h3C);
    step(0, 1, 1, 1, 1, 8'h12);
    chk("rst_wins_count", 0, act_cnt(0), 0);
    chk("rst_wins_flags", 0, {30'd0, ov[0], un[0]}, 0);
    fill_and_wrap(1);
    step(1, 0, 0, 0, 1, 8'h00);
    chk("d3_unf", 1, 32'(un[1]), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
